pc_unit: RTL and testbench

Program-counter unit of the pipelined MIPS-style CPU. It holds the fetch address and each cycle selects the next PC: sequential, jump (j/jal), jump-register (jr), beq/bne, or bltz. It flags taken redirects so the pipeline can flush. It also keeps performance counters for total cycles, unconditional jumps, conditional branches and taken conditional branches.

---
 rtl/pc_unit.sv | 107 ++++++++++
 tb/tb_pc_unit.sv | 135 +++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program-counter unit: selects the next fetch address (sequential, j/jal, jr,
// beq/bne, bltz), flags taken redirects, and keeps performance counters.
module pc_unit #(
    parameter int          COUNTER_WIDTH = 25,
    parameter logic [31:0] RESET_PC      = 32'h0000_0000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [31:0]              originalPc,
    input  logic [31:0]              regSValue,
    input  logic [25:0]              instruction,
    input  logic [1:0]               pcWrite,
    input  logic                     aluEqual,
    input  logic                     enable,
    input  logic                     jump,
    input  logic                     bltz,
    input  logic                     bubble,
    output logic                     jumped,
    output logic [31:0]              pc,
    output logic [COUNTER_WIDTH-1:0] totalCycle,
    output logic [COUNTER_WIDTH-1:0] unconditionalJump,
    output logic [COUNTER_WIDTH-1:0] conditionalJump,
    output logic [COUNTER_WIDTH-1:0] conditionalSuccessfulJump
);

    localparam logic [1:0] PW_NONE = 2'd0;
    localparam logic [1:0] PW_JR   = 2'd1;
    localparam logic [1:0] PW_BEQ  = 2'd2;
    localparam logic [1:0] PW_BNE  = 2'd3;
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);

    typedef struct packed {
        logic        taken;
        logic        uncond;
        logic        cond;
        logic [31:0] target;
    } sel_t;

    logic [31:0] base;
    logic [31:0] offset;
    logic [31:0] br_target;
    logic [31:0] seq_pc;
    logic [31:0] next_pc;
    logic        advance;
    sel_t        sel;

    assign base      = originalPc + 32'd4;
    assign offset    = {{14{instruction[15]}}, instruction[15:0], 2'b00};
    assign br_target = base + offset;
    assign seq_pc    = pc + 32'd4;

    // Priority chain: only the highest-priority event is acted on and counted.
    always_comb begin
        sel = '{taken: 1'b0, uncond: 1'b0, cond: 1'b0, target: seq_pc};
        if (jump) begin
            sel.taken  = 1'b1;
            sel.uncond = 1'b1;
            sel.target = {base[31:28], instruction, 2'b00};
        end else if (pcWrite == PW_JR) begin
            sel.taken  = 1'b1;
            sel.uncond = 1'b1;
            sel.target = regSValue;
        end else if (pcWrite == PW_BEQ) begin
            sel.cond   = 1'b1;
            sel.taken  = aluEqual;
            sel.target = br_target;
        end else if (pcWrite == PW_BNE) begin
            sel.cond   = 1'b1;
            sel.taken  = ~aluEqual;
            sel.target = br_target;
        end else if (bltz) begin
            sel.cond   = 1'b1;
            sel.taken  = regSValue[31];
            sel.target = br_target;
        end
    end

    assign next_pc = sel.taken ? sel.target : seq_pc;
    assign advance = enable & ~bubble;
    assign jumped  = reset & advance & sel.taken;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc                        <= RESET_PC;
            totalCycle                <= '0;
            unconditionalJump         <= '0;
            conditionalJump           <= '0;
            conditionalSuccessfulJump <= '0;
        end else if (enable) begin
            // A stalled cycle is still an enabled cycle.
            totalCycle <= totalCycle + CNT_ONE;
            if (!bubble) begin
                pc <= next_pc;
                if (sel.uncond)
                    unconditionalJump <= unconditionalJump + CNT_ONE;
                if (sel.cond)
                    conditionalJump <= conditionalJump + CNT_ONE;
                if (sel.cond && sel.taken)
                    conditionalSuccessfulJump <= conditionalSuccessfulJump + CNT_ONE;
            end
        end
    end

    logic unused_pw;
    assign unused_pw = (PW_NONE == 2'd0);

endmodule

// File: tb/tb_pc_unit.sv
// Directed vector bench for pc_unit: table of per-cycle controls with
// hand-computed jumped/pc/counter expectations, plus reset corner sequences.
module tb_pc_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] originalPc, regSValue;
    logic [25:0] instruction;
    logic [1:0]  pcWrite;
    logic        aluEqual, enable, jump, bltz, bubble;
    logic        jumped;
    logic [31:0] pc;
    logic [24:0] totalCycle, unconditionalJump, conditionalJump, conditionalSuccessfulJump;

    int checks   = 0;
    int failures = 0;

    pc_unit #(.COUNTER_WIDTH(25), .RESET_PC(32'h0)) dut (
        .clock(clock), .reset(reset), .originalPc(originalPc), .regSValue(regSValue),
        .instruction(instruction), .pcWrite(pcWrite), .aluEqual(aluEqual),
        .enable(enable), .jump(jump), .bltz(bltz), .bubble(bubble),
        .jumped(jumped), .pc(pc), .totalCycle(totalCycle),
        .unconditionalJump(unconditionalJump), .conditionalJump(conditionalJump),
        .conditionalSuccessfulJump(conditionalSuccessfulJump)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] opc;
        logic [31:0] rs;
        logic [25:0] ins;
        logic [1:0]  pw;
        logic        eq, en, jp, bl, bb;
        logic        ej;
        logic [31:0] epc;
        int          tc, uj, cj, cs;
    } vec_t;

    localparam int NV = 18;
    vec_t v [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_counters(input string tag, input int tc, input int uj, input int cj, input int cs);
        chk({tag, " totalCycle"}, 32'(totalCycle), 32'(tc));
        chk({tag, " unconditionalJump"}, 32'(unconditionalJump), 32'(uj));
        chk({tag, " conditionalJump"}, 32'(conditionalJump), 32'(cj));
        chk({tag, " conditionalSuccessfulJump"}, 32'(conditionalSuccessfulJump), 32'(cs));
    endtask

    task automatic idle_inputs();
        originalPc = 0; regSValue = 0; instruction = 0; pcWrite = 0;
        aluEqual = 0; enable = 1; jump = 0; bltz = 0; bubble = 0;
    endtask

    initial begin
        //        opc           rs            ins          pw eq en jp bl bb  ej epc           tc uj cj cs
        v[0]  = '{32'h0,        32'h0,        26'h0,       0, 0, 1, 0, 0, 0,  0, 32'h4,        1, 0, 0, 0};
        v[1]  = '{32'h0,        32'h0,        26'h0,       0, 0, 1, 0, 0, 0,  0, 32'h8,        2, 0, 0, 0};
        v[2]  = '{32'h0,        32'h0,        26'h0,       0, 0, 1, 0, 0, 0,  0, 32'hC,        3, 0, 0, 0};
        v[3]  = '{32'h0,        32'h0,        26'h0c25,    0, 0, 1, 1, 0, 0,  1, 32'h3094,     4, 1, 0, 0};
        v[4]  = '{32'h0,        32'd4000,     26'h0,       1, 0, 1, 0, 0, 0,  1, 32'd4000,     5, 2, 0, 0};
        v[5]  = '{32'h0,        32'd8,        26'h0,       1, 0, 1, 0, 0, 0,  1, 32'd8,        6, 3, 0, 0};
        v[6]  = '{32'h0,        32'h0,        26'h0c64,    2, 1, 1, 0, 0, 0,  1, 32'h3194,     7, 3, 1, 1};
        v[7]  = '{32'h0,        32'h0,        26'h0c64,    2, 0, 1, 0, 0, 0,  0, 32'h3198,     8, 3, 2, 1};
        v[8]  = '{32'h0,        32'h0,        26'h0c64,    3, 0, 1, 0, 0, 0,  1, 32'h3194,     9, 3, 3, 2};
        v[9]  = '{32'h0,        32'h0,        26'h0c64,    3, 1, 1, 0, 0, 0,  0, 32'h3198,    10, 3, 4, 2};
        v[10] = '{32'h0,        32'hFFFFFFFF, 26'h4,       0, 0, 1, 0, 1, 0,  1, 32'h14,      11, 3, 5, 3};
        v[11] = '{32'h0,        32'h1,        26'h4,       0, 0, 1, 0, 1, 0,  0, 32'h18,      12, 3, 6, 3};
        // jump outranks a simultaneous taken beq; counted as unconditional only
        v[12] = '{32'h0,        32'h0,        26'h0c64,    2, 1, 1, 1, 0, 0,  1, 32'h3190,    13, 4, 6, 3};
        v[13] = '{32'h0,        32'h0,        26'h0c25,    0, 0, 0, 1, 0, 0,  0, 32'h3190,    13, 4, 6, 3};
        v[14] = '{32'h0,        32'h100,      26'h0,       1, 0, 1, 0, 0, 1,  0, 32'h3190,    14, 4, 6, 3};
        v[15] = '{32'h100,      32'h0,        26'hFFFF,    2, 1, 1, 0, 0, 0,  1, 32'h100,     15, 4, 7, 4};
        v[16] = '{32'hF0000000, 32'h0,        26'h3FFFFFF, 0, 0, 1, 1, 0, 0,  1, 32'hFFFFFFFC, 16, 5, 7, 4};
        v[17] = '{32'h0,        32'h0,        26'h0,       0, 0, 1, 0, 0, 0,  0, 32'h0,       17, 5, 7, 4};

        idle_inputs();
        jump  = 1'b1;
        reset = 1'b0;
        #2;
        chk("reset pc", pc, 32'h0);
        chk("reset jumped", 32'(jumped), 32'h0);
        chk_counters("reset", 0, 0, 0, 0);
        @(negedge clock);
        idle_inputs();
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            originalPc = v[i].opc; regSValue = v[i].rs; instruction = v[i].ins;
            pcWrite = v[i].pw; aluEqual = v[i].eq; enable = v[i].en;
            jump = v[i].jp; bltz = v[i].bl; bubble = v[i].bb;
            #1;
            chk($sformatf("v%0d jumped", i), 32'(jumped), 32'(v[i].ej));
            @(posedge clock);
            #1;
            chk($sformatf("v%0d pc", i), pc, v[i].epc);
            chk_counters($sformatf("v%0d", i), v[i].tc, v[i].uj, v[i].cj, v[i].cs);
            @(negedge clock);
        end

        // Mid-cycle asynchronous reset clears state with no clock edge involved.
        jump = 1'b1; instruction = 26'h0c25;
        @(posedge clock);
        #1;
        chk("pre-async pc", pc, 32'h3094);
        #2;
        reset = 1'b0;
        #1;
        chk("async pc", pc, 32'h0);
        chk("async jumped", 32'(jumped), 32'h0);
        chk_counters("async", 0, 0, 0, 0);
        @(posedge clock);
        #1;
        chk("held-in-reset pc", pc, 32'h0);
        @(negedge clock);
        idle_inputs();
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("post-reset pc", pc, 32'h4);
        chk_counters("post-reset", 1, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
